uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
// Next-generation UART receiver. Adds runtime-configurable frame format (5-8 data bits, 1/2 stop bits, optional parity)
// and 3-sample majority voting at mid-bit. Adds error flagging per frame and an output FIFO with valid/ready handshake.
// Sits between the pad synchroniser-free rx pin and the TileLink UART register block, which pops bytes and error status.
// PARAMETERS
// DIV_W        16  width of bauddiv_i; bit period = bauddiv_i+1 clocks
// FIFO_DEPTH   4   receive FIFO entries, power of two, >=2
// PORTS
// clock            in   1       system clock, all logic on posedge
// reset            in   1       synchronous, active-high reset
// bauddiv_i        in   DIV_W   clocks-per-bit minus 1; legal >=3; sampled only in IDLE
// data_bits_i      in   2       data bits minus 5 (0=5 .. 3=8); sampled only in IDLE
// stop2_i          in   1       1 = two stop bits checked
// parity_en_i      in   1       1 = parity bit present after data
// parity_odd_i     in   1       1 = odd parity, 0 = even
// rx_i             in   1       asynchronous serial input, idle high
// rx_data_o        out  8       FIFO head data, LSB first received; unused MSBs zero
// rx_frame_err_o   out  1       FIFO head: a stop bit sampled low
// rx_parity_err_o  out  1       FIFO head: parity mismatch
// rx_valid_o       out  1       FIFO non-empty
// rx_ready_i       in   1       pop FIFO head when rx_valid_o && rx_ready_i
// overrun_o        out  1       sticky: frame dropped because FIFO full
// overrun_clr_i    in   1       clears overrun_o
// rx_busy_o        out  1       state != IDLE
// BEHAVIOUR
// - rx_i passes a 2-flop synchroniser (reset value 1) -> rxs. All sampling uses rxs.
// - Reset: state IDLE, counter 0, FIFO empty, all outputs 0 except rx_data_o=0 (FIFO storage need not reset).
// - Latched config: bauddiv, data bits, stop2, parity_en, and parity_odd are captured on IDLE->START.
//   A mid-frame config change has no effect.
// - Counter: loads bauddiv on each state entry and bit advance, then decrements; bit boundary at counter==0.
//   Let H = bauddiv>>1. Samples are taken at counter==H+1, H, and H-1. Bit value = majority of the 3 samples,
//   valid at counter==H-1 ("mid").
// - FSM
//   IDLE   : rxs==0 -> START (counter loaded). rxs==1 -> stay.
//   START  : at mid, majority==1 -> IDLE; glitch rejected, nothing pushed. At counter==0 -> DATA, bit index 0.
//   DATA   : at mid, shift the bit in LSB-first. At counter==0, the last data bit goes to PARITY if parity_en,
//            else to STOP; otherwise bit index increments.
//   PARITY : at mid, parity error = XOR(data bits, sampled bit) != parity_odd. At counter==0 -> STOP.
//   STOP   : at mid, a low sample sets frame_err. With stop2 and first stop bit, go to STOP at counter==0.
//            On the final stop bit, at mid the frame is pushed and the FSM goes to IDLE immediately (half-bit early),
//            so a back-to-back start edge is caught.
// - Frame word: rx_data_o is right-justified to data_bits; the upper bits are zero.
// - Push/pop: push and pop in the same cycle are both honoured; count is unchanged.
//   Push when full (no pop that cycle): the frame is dropped and overrun_o is set.
//   overrun_clr_i and a new overrun in the same cycle: overrun_o stays 1.
// - Handshake: rx_valid_o is asserted the cycle after a push into an empty FIFO.
//   Head data is stable while valid && !ready.
// - Break (line held low): reported as a frame with data 0x00 and frame_err=1. The FSM then waits in IDLE;
//   the next start bit is only recognised after rxs returns high, then falls.
// - Reset mid-frame: FSM returns to IDLE and the partial frame is discarded. FIFO is emptied and overrun_o cleared.
// CONFIGURATION
// - UART_RX_PARITY_EN defined: PARITY state and parity check as above.
// - UART_RX_PARITY_EN undefined: PARITY state removed; parity_en_i and parity_odd_i are ignored (ports kept);
//   rx_parity_err_o is tied 0 and not stored in the FIFO.
// TESTING (bauddiv_i=15, 16 clocks/bit, unless stated)
// - 8N1, send 0xA5 -> one pop returns data 0xA5, frame_err=0, parity_err=0. valid rises ~9.5 bit times after start edge.
// - 7E1 (data_bits_i=2, parity_en=1, odd=0), send 0x41 with parity bit 1 (wrong) -> data 0x41, parity_err=1.
//   Same frame with parity bit 0 -> parity_err=0.
// - 5N2, second stop bit driven low -> data correct, frame_err=1. Next frame starting immediately is received intact.
// - Start glitch: rx_i low for 6 clocks then high -> no push, rx_busy_o returns 0 within 16 clocks.
//   A 1-clock spike mid-data bit is outvoted.
// - rx_ready_i=0, send FIFO_DEPTH+1 bytes 0x01..0x05 -> pops return 0x01..0x04, overrun_o=1.
//   overrun_clr_i pulse -> overrun_o=0.
// - reset asserted mid-DATA of byte 0x3C, released, byte 0x5A sent -> only 0x5A popped.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// UART receiver with runtime frame format, 3-sample majority voting and a receive FIFO.
// Optional parity support is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_cfg #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DIV_W-1:0] bauddiv_i,
  input  logic [1:0]       data_bits_i,
  input  logic             stop2_i,
  input  logic             parity_en_i,
  input  logic             parity_odd_i,
  input  logic             rx_i,
  output logic [7:0]       rx_data_o,
  output logic             rx_frame_err_o,
  output logic             rx_parity_err_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             overrun_o,
  input  logic             overrun_clr_i,
  output logic             rx_busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  // --------------------------------------------------------------------------
  // Input synchroniser
  // --------------------------------------------------------------------------
  logic rx_meta;
  logic rxs;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its source, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  state_e           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] bd_q;
  logic [1:0]       db_q;
  logic             stop2_q;
  logic [2:0]       bit_idx;
  logic             stop_idx;
  logic [7:0]       sh;
  logic             s0;
  logic             s1;
  logic             ferr;
  logic             armed;
  logic             push_q;
  logic [7:0]       push_data;
  logic             push_ferr;
`ifdef UART_RX_PARITY_EN
  logic             par_en_q;
  logic             par_odd_q;
  logic             perr;
  logic             push_perr;
`endif

  logic [DIV_W-1:0] h;
  logic [DIV_W-1:0] h_p1;
  logic [DIV_W-1:0] h_m1;
  logic             at_mid;
  logic             at_end;
  logic             maj;
  logic [2:0]       last_idx;
  logic             ferr_final;
  logic [7:0]       frame_data;

  assign h          = bd_q >> 1;
  assign h_p1       = h + DIV_W'(1);
  assign h_m1       = h - DIV_W'(1);
  assign at_mid     = (cnt == h_m1);
  assign at_end     = (cnt == '0);
  assign maj        = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign last_idx   = {1'b0, db_q} + 3'd4;
  assign ferr_final = ferr | ~maj;
  // Bits arrive at the top of sh; shifting by 3-db_q right-justifies the word.
  assign frame_data = sh >> (~db_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bd_q      <= '0;
      db_q      <= '0;
      stop2_q   <= 1'b0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      sh        <= '0;
      s0        <= 1'b1;
      s1        <= 1'b1;
      ferr      <= 1'b0;
      armed     <= 1'b0;
      push_q    <= 1'b0;
      push_data <= '0;
      push_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      perr      <= 1'b0;
      push_perr <= 1'b0;
`endif
    end else begin
      push_q <= 1'b0;
      if (state != S_IDLE) begin
        cnt <= cnt - DIV_W'(1);
        if (cnt == h_p1) s0 <= rxs;
        if (cnt == h)    s1 <= rxs;
      end

      unique case (state)
        S_IDLE: begin
          // A start edge needs the line to have been high first, so a held
          // break does not retrigger frames.
          if (rxs) begin
            armed <= 1'b1;
          end else if (armed) begin
            state     <= S_START;
            cnt       <= bauddiv_i;
            bd_q      <= bauddiv_i;
            db_q      <= data_bits_i;
            stop2_q   <= stop2_i;
            armed     <= 1'b0;
            sh        <= '0;
            ferr      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_q  <= parity_en_i;
            par_odd_q <= parity_odd_i;
            perr      <= 1'b0;
`endif
          end
        end

        S_START: begin
          if (at_mid && maj) begin
            state <= S_IDLE;
          end else if (at_end) begin
            state   <= S_DATA;
            cnt     <= bd_q;
            bit_idx <= '0;
          end
        end

        S_DATA: begin
          if (at_mid) sh <= {maj, sh[7:1]};
          if (at_end) begin
            cnt <= bd_q;
            if (bit_idx == last_idx) begin
              stop_idx <= 1'b0;
`ifdef UART_RX_PARITY_EN
              state    <= par_en_q ? S_PARITY : S_STOP;
`else
              state    <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (at_mid) perr <= ((^sh) ^ maj) != par_odd_q;
          if (at_end) begin
            state    <= S_STOP;
            stop_idx <= 1'b0;
            cnt      <= bd_q;
          end
        end
`endif

        S_STOP: begin
          if (at_mid) begin
            if (stop2_q && !stop_idx) begin
              ferr <= ferr_final;
            end else begin
              // Leave half a bit early so a back-to-back start edge is seen.
              state     <= S_IDLE;
              push_q    <= 1'b1;
              push_data <= frame_data;
              push_ferr <= ferr_final;
`ifdef UART_RX_PARITY_EN
              push_perr <= perr;
`endif
            end
          end
          if (at_end && stop2_q && !stop_idx) begin
            stop_idx <= 1'b1;
            cnt      <= bd_q;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign rx_busy_o = (state != S_IDLE);

  // --------------------------------------------------------------------------
  // Receive FIFO
  // --------------------------------------------------------------------------
  logic [7:0] mem_data [FIFO_DEPTH];
  logic       mem_ferr [FIFO_DEPTH];
`ifdef UART_RX_PARITY_EN
  logic       mem_perr [FIFO_DEPTH];
`endif
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] fill;
  logic        full;
  logic        empty;
  logic        pop;
  logic        push_ok;
  logic        drop;

  assign fill    = wr_ptr - rd_ptr;
  assign full    = (fill == (AW+1)'(FIFO_DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign pop     = !empty && rx_ready_i;
  assign push_ok = push_q && (!full || pop);
  assign drop    = push_q && full && !pop;

  // NOTE: storage has no reset; the head outputs are gated by empty, so stale
  // contents are never visible and the array can map to plain registers/RAM.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_data[wr_ptr[AW-1:0]] <= push_data;
      mem_ferr[wr_ptr[AW-1:0]] <= push_ferr;
`ifdef UART_RX_PARITY_EN
      mem_perr[wr_ptr[AW-1:0]] <= push_perr;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop)               overrun_o <= 1'b1;
      else if (overrun_clr_i) overrun_o <= 1'b0;
    end
  end

  assign rx_valid_o     = !empty;
  assign rx_data_o      = empty ? 8'h00 : mem_data[rd_ptr[AW-1:0]];
  assign rx_frame_err_o = !empty && mem_ferr[rd_ptr[AW-1:0]];
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err_o = !empty && mem_perr[rd_ptr[AW-1:0]];
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = parity_en_i ^ parity_odd_i;
  assign rx_parity_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed self-checking bench for uart_rx_cfg; expectations follow UART_RX_PARITY_EN.
module tb_uart_rx_cfg;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] bauddiv_i = 16'd15;
  logic [1:0]  data_bits_i = 2'd3;
  logic        stop2_i = 1'b0;
  logic        parity_en_i = 1'b0;
  logic        parity_odd_i = 1'b0;
  logic        rx_i = 1'b1;
  logic        rx_ready_i = 1'b0;
  logic        overrun_clr_i = 1'b0;
  logic [7:0]  rx_data_o;
  logic        rx_frame_err_o;
  logic        rx_parity_err_o;
  logic        rx_valid_o;
  logic        overrun_o;
  logic        rx_busy_o;

  int n_cmp = 0;
  int n_bad = 0;
  int bit_clks = 16;

  uart_rx_cfg #(.DIV_W(16), .FIFO_DEPTH(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .bauddiv_i       (bauddiv_i),
    .data_bits_i     (data_bits_i),
    .stop2_i         (stop2_i),
    .parity_en_i     (parity_en_i),
    .parity_odd_i    (parity_odd_i),
    .rx_i            (rx_i),
    .rx_data_o       (rx_data_o),
    .rx_frame_err_o  (rx_frame_err_o),
    .rx_parity_err_o (rx_parity_err_o),
    .rx_valid_o      (rx_valid_o),
    .rx_ready_i      (rx_ready_i),
    .overrun_o       (overrun_o),
    .overrun_clr_i   (overrun_clr_i),
    .rx_busy_o       (rx_busy_o)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bit period; spike_off>0 inverts the line for that single clock of the bit.
  task automatic drive_bit(input logic b, input int spike_off);
    rx_i = b;
    if (spike_off > 0) begin
      repeat (spike_off - 1) tick();
      rx_i = ~b;
      tick();
      rx_i = b;
      repeat (bit_clks - spike_off) tick();
    end else begin
      repeat (bit_clks) tick();
    end
  endtask

  // par < 0: no parity bit. stops[i] is the level of stop bit i.
  task automatic send_frame(input logic [7:0] d, input int nbits, input int par,
                            input logic [1:0] stops, input int nstop,
                            input int spike_bit, input int spike_off);
    drive_bit(1'b0, 0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i], (i == spike_bit) ? spike_off : 0);
    if (par >= 0) drive_bit(par[0], 0);
    for (int i = 0; i < nstop; i++) drive_bit(stops[i], 0);
    rx_i = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] d, input logic fe, input logic pe);
    int t = 0;
    while (rx_valid_o !== 1'b1 && t < 400) begin
      tick();
      t++;
    end
    check({tag, " valid"}, rx_valid_o, 8'd1);
    check({tag, " data"}, rx_data_o, d);
    check({tag, " ferr"}, rx_frame_err_o, fe);
    check({tag, " perr"}, rx_parity_err_o, pe);
    rx_ready_i = 1'b1;
    tick();
    rx_ready_i = 1'b0;
  endtask

  initial begin
    repeat (4) tick();
    reset = 1'b0;
    tick();

    check("rst valid", rx_valid_o, 8'd0);
    check("rst data", rx_data_o, 8'h00);
    check("rst ferr", rx_frame_err_o, 8'd0);
    check("rst perr", rx_parity_err_o, 8'd0);
    check("rst busy", rx_busy_o, 8'd0);
    check("rst overrun", overrun_o, 8'd0);

    // 8N1
    send_frame(8'hA5, 8, -1, 2'b11, 1, -1, 0);
    pop_check("8n1_a5", 8'hA5, 1'b0, 1'b0);
    check("8n1 empty", rx_valid_o, 8'd0);

    // 7-bit frames with parity_en set
    data_bits_i = 2'd2;
    parity_en_i = 1'b1;
`ifdef UART_RX_PARITY_EN
    parity_odd_i = 1'b0;
    send_frame(8'h41, 7, 1, 2'b11, 1, -1, 0);
    pop_check("7e1_bad", 8'h41, 1'b0, 1'b1);
    send_frame(8'h41, 7, 0, 2'b11, 1, -1, 0);
    pop_check("7e1_good", 8'h41, 1'b0, 1'b0);
    parity_odd_i = 1'b1;
    send_frame(8'h41, 7, 1, 2'b11, 1, -1, 0);
    pop_check("7o1_good", 8'h41, 1'b0, 1'b0);
`else
    send_frame(8'h41, 7, -1, 2'b11, 1, -1, 0);
    pop_check("7x1_ignored", 8'h41, 1'b0, 1'b0);
`endif
    parity_en_i  = 1'b0;
    parity_odd_i = 1'b0;

    // 5N2, second stop low, then a clean frame
    data_bits_i = 2'd0;
    stop2_i     = 1'b1;
    send_frame(8'h15, 5, -1, 2'b01, 2, -1, 0);
    drive_bit(1'b1, 0);
    send_frame(8'h0A, 5, -1, 2'b11, 2, -1, 0);
    pop_check("5n2_ferr", 8'h15, 1'b1, 1'b0);
    pop_check("5n2_next", 8'h0A, 1'b0, 1'b0);
    stop2_i     = 1'b0;
    data_bits_i = 2'd3;

    // back-to-back 8N1 frames with no idle gap
    send_frame(8'h81, 8, -1, 2'b11, 1, -1, 0);
    send_frame(8'h7E, 8, -1, 2'b11, 1, -1, 0);
    pop_check("b2b_1", 8'h81, 1'b0, 1'b0);
    pop_check("b2b_2", 8'h7E, 1'b0, 1'b0);

    // start glitch
    rx_i = 1'b0;
    repeat (6) tick();
    check("glitch busy", rx_busy_o, 8'd1);
    rx_i = 1'b1;
    repeat (16) tick();
    check("glitch idle", rx_busy_o, 8'd0);
    check("glitch nopush", rx_valid_o, 8'd0);

    // single-clock spikes at each of the three sample positions
    send_frame(8'h55, 8, -1, 2'b11, 1, 3, 9);
    send_frame(8'h55, 8, -1, 2'b11, 1, 4, 10);
    send_frame(8'h55, 8, -1, 2'b11, 1, 5, 11);
    pop_check("spike_a", 8'h55, 1'b0, 1'b0);
    pop_check("spike_b", 8'h55, 1'b0, 1'b0);
    pop_check("spike_c", 8'h55, 1'b0, 1'b0);

    // minimum divider: mid sample coincides with the bit boundary
    bauddiv_i = 16'd3;
    bit_clks  = 4;
    send_frame(8'h6B, 8, -1, 2'b11, 1, -1, 0);
    pop_check("div3", 8'h6B, 1'b0, 1'b0);
    bauddiv_i = 16'd15;
    bit_clks  = 16;

    // overrun
    for (int v = 1; v <= 5; v++) send_frame(8'(v), 8, -1, 2'b11, 1, -1, 0);
    check("ovr set", overrun_o, 8'd1);
    for (int v = 1; v <= 4; v++) pop_check("ovr_pop", 8'(v), 1'b0, 1'b0);
    check("ovr empty", rx_valid_o, 8'd0);
    check("ovr sticky", overrun_o, 8'd1);
    overrun_clr_i = 1'b1;
    tick();
    overrun_clr_i = 1'b0;
    check("ovr clr", overrun_o, 8'd0);

    // mid-frame config change is ignored
    drive_bit(1'b0, 0);
    data_bits_i = 2'd0;
    stop2_i     = 1'b1;
    bauddiv_i   = 16'd7;
    for (int i = 0; i < 8; i++) drive_bit(i[0] ^ i[1] ^ i[2] ? 1'b1 : 1'b0, 0);
    drive_bit(1'b1, 0);
    data_bits_i = 2'd3;
    stop2_i     = 1'b0;
    bauddiv_i   = 16'd15;
    // bits 0..7 = 0,1,1,0,1,0,0,1 -> 0x96
    pop_check("cfg_hold", 8'h96, 1'b0, 1'b0);

    // reset in the middle of a frame, with one frame already queued
    send_frame(8'h11, 8, -1, 2'b11, 1, -1, 0);
    drive_bit(1'b0, 0);
    drive_bit(1'b0, 0);
    drive_bit(1'b0, 0);
    drive_bit(1'b1, 0);
    repeat (5) tick();
    check("rstmid busy", rx_busy_o, 8'd1);
    reset = 1'b1;
    rx_i  = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("rstmid idle", rx_busy_o, 8'd0);
    check("rstmid flush", rx_valid_o, 8'd0);
    repeat (32) tick();
    send_frame(8'h5A, 8, -1, 2'b11, 1, -1, 0);
    pop_check("rstmid_5a", 8'h5A, 1'b0, 1'b0);
    check("rstmid only", rx_valid_o, 8'd0);

    // break: line low for 12 bit times
    rx_i = 1'b0;
    repeat (12 * 16) tick();
    check("brk wait", rx_busy_o, 8'd0);
    rx_i = 1'b1;
    repeat (32) tick();
    send_frame(8'hC3, 8, -1, 2'b11, 1, -1, 0);
    pop_check("brk", 8'h00, 1'b1, 1'b0);
    pop_check("brk_next", 8'hC3, 1'b0, 1'b0);
    check("brk empty", rx_valid_o, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
